// File: rtl/tpu_job_scheduler.sv
// tpu_job_scheduler
// Job-level sequencer in front of the TPU core. Host descriptors (weight/data
// SRAM base + tag) are queued in a small FIFO. The core is launched for one job
// at a time, and a watchdog bounds how long each job may run. Every launched job
// returns one completion record (tag + done/timeout status).
//
// Ports
//   clk, srstn            clock / asynchronous active-low reset
//   sched_enable          gates IDLE->LAUNCH only
//   job_valid/job_ready   descriptor push handshake (job_w_base, job_d_base, job_id)
//   tpu_start             one-cycle launch pulse
//   tpu_w_base/d_base     active job bases, held from LAUNCH through CPL
//   tpu_done              core completion, honoured in RUN only
//   tpu_abort             one-cycle flush request on timeout
//   cpl_valid/cpl_ready   completion handshake (cpl_id, cpl_status: 0 done, 1 timeout)
//   busy                  job active or FIFO non-empty
//   jobs_ok               accepted done completions, wraps
//   jobs_timeout          accepted timeout completions, saturates
//
// state  | meaning
// IDLE   | no active job; pops the head when enabled and FIFO non-empty
// LAUNCH | tpu_start pulse, watchdog cleared
// RUN    | waiting for tpu_done under the watchdog
// CPL    | completion record presented until the host accepts it
module tpu_job_scheduler #(
  parameter int JOB_DEPTH       = 4,
  parameter int SRAM_ADDR_WIDTH = 10,
  parameter int ID_BITS         = 4,
  parameter int TIMEOUT_CYCLES  = 1023,
  parameter int TIMER_BITS      = 10,
  parameter int CNT_BITS        = 8
) (
  input  logic                       clk,
  input  logic                       srstn,
  input  logic                       sched_enable,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [SRAM_ADDR_WIDTH-1:0] job_w_base,
  input  logic [SRAM_ADDR_WIDTH-1:0] job_d_base,
  input  logic [ID_BITS-1:0]         job_id,
  output logic                       tpu_start,
  output logic [SRAM_ADDR_WIDTH-1:0] tpu_w_base,
  output logic [SRAM_ADDR_WIDTH-1:0] tpu_d_base,
  input  logic                       tpu_done,
  output logic                       tpu_abort,
  output logic                       cpl_valid,
  input  logic                       cpl_ready,
  output logic [ID_BITS-1:0]         cpl_id,
  output logic                       cpl_status,
  output logic                       busy,
  output logic [CNT_BITS-1:0]        jobs_ok,
  output logic [CNT_BITS-1:0]        jobs_timeout
);

  localparam int PTR_BITS = $clog2(JOB_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_CPL} state_t;

  state_t r_state, w_state_nxt;

  logic [SRAM_ADDR_WIDTH-1:0] r_fifo_w  [JOB_DEPTH];
  logic [SRAM_ADDR_WIDTH-1:0] r_fifo_d  [JOB_DEPTH];
  logic [ID_BITS-1:0]         r_fifo_id [JOB_DEPTH];

  // One extra pointer bit distinguishes full from empty.
  logic [PTR_BITS:0]          r_wptr, r_rptr;
  logic [PTR_BITS:0]          w_count;
  logic                       w_empty, w_push, w_pop, w_timer_tc;

  logic [TIMER_BITS-1:0]      r_timer;
  logic [SRAM_ADDR_WIDTH-1:0] r_w_base, r_d_base;
  logic [ID_BITS-1:0]         r_id;
  logic                       r_status, r_abort;
  logic [CNT_BITS-1:0]        r_ok, r_to;

  assign w_count    = r_wptr - r_rptr;
  assign w_empty    = (r_wptr == r_rptr);
  assign job_ready  = (w_count != (PTR_BITS+1)'(JOB_DEPTH));
  assign w_push     = job_valid & job_ready;
  assign w_pop      = (r_state == S_IDLE) & sched_enable & ~w_empty;
  assign w_timer_tc = (r_timer == TIMER_BITS'(TIMEOUT_CYCLES - 1));

  // Descriptor storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_w[r_wptr[PTR_BITS-1:0]]  <= job_w_base;
      r_fifo_d[r_wptr[PTR_BITS-1:0]]  <= job_d_base;
      r_fifo_id[r_wptr[PTR_BITS-1:0]] <= job_id;
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_pop) w_state_nxt = S_LAUNCH;
      S_LAUNCH: w_state_nxt = S_RUN;
      S_RUN:    if (tpu_done || w_timer_tc) w_state_nxt = S_CPL;
      S_CPL:    if (cpl_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      r_timer  <= '0;
      r_w_base <= '0;
      r_d_base <= '0;
      r_id     <= '0;
      r_status <= 1'b0;
      r_abort  <= 1'b0;
      r_ok     <= '0;
      r_to     <= '0;
    end else begin
      // Abort only flags the first CPL cycle of a timed-out job; done wins a tie.
      r_abort <= (r_state == S_RUN) & ~tpu_done & w_timer_tc;

      if (w_pop) begin
        r_w_base <= r_fifo_w[r_rptr[PTR_BITS-1:0]];
        r_d_base <= r_fifo_d[r_rptr[PTR_BITS-1:0]];
        r_id     <= r_fifo_id[r_rptr[PTR_BITS-1:0]];
      end

      if (r_state == S_LAUNCH)   r_timer <= '0;
      else if (r_state == S_RUN) r_timer <= r_timer + 1'b1;

      if (r_state == S_RUN) begin
        if (tpu_done)        r_status <= 1'b0;
        else if (w_timer_tc) r_status <= 1'b1;
      end

      if ((r_state == S_CPL) && cpl_ready) begin
        if (r_status) begin
          if (r_to != '1) r_to <= r_to + 1'b1;
        end else begin
          r_ok <= r_ok + 1'b1;
        end
      end
    end
  end

  assign tpu_start    = (r_state == S_LAUNCH);
  assign cpl_valid    = (r_state == S_CPL);
  assign busy         = (r_state != S_IDLE) | ~w_empty;
  assign tpu_abort    = r_abort;
  assign tpu_w_base   = r_w_base;
  assign tpu_d_base   = r_d_base;
  assign cpl_id       = r_id;
  assign cpl_status   = r_status;
  assign jobs_ok      = r_ok;
  assign jobs_timeout = r_to;

endmodule
